// File: rtl/nativephy_link_pkg.sv
// rtl/nativephy_link_pkg.sv - shared CSR addresses, version and lock FSM states
package nativephy_link_pkg;

    localparam logic [3:0] ADDR_LPBK_CTRL   = 4'd0;
    localparam logic [3:0] ADDR_PLL_LOCKED  = 4'd1;
    localparam logic [3:0] ADDR_RX_LTR      = 4'd2;
    localparam logic [3:0] ADDR_RX_STABLE   = 4'd3;
    localparam logic [3:0] ADDR_LOSS_STICKY = 4'd4;
    localparam logic [3:0] ADDR_IRQ_EN      = 4'd5;
    localparam logic [3:0] ADDR_CNT_SEL     = 4'd6;
    localparam logic [3:0] ADDR_LOSS_CNT    = 4'd7;
    localparam logic [3:0] ADDR_VERSION     = 4'd8;

    localparam logic [31:0] VERSION_VALUE = 32'h0002_0000;

    typedef enum logic [1:0] {
        UNLOCKED = 2'd0,
        QUALIFY  = 2'd1,
        LOCKED   = 2'd2
    } lock_state_e;

endpackage

// File: rtl/nativephy_lock_qual.sv
// rtl/nativephy_lock_qual.sv - one channel: lock synchroniser, stability qualifier, loss sticky and counter
module nativephy_lock_qual
    import nativephy_link_pkg::*;
#(
    parameter int CNT_W       = 16,
    parameter int SYNC_STAGES = 2,
    parameter int STABLE_CYC  = 1024
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             pll_locked,
    input  logic             rx_is_lockedtoref,
    input  logic             relock,
    input  logic             sticky_clr,
    input  logic             cnt_clr,
    output logic             pll_locked_s,
    output logic             rx_is_lockedtoref_s,
    output logic             stable,
    output logic             loss_sticky,
    output logic [CNT_W-1:0] loss_cnt
);

    localparam int QCNT_W = (STABLE_CYC > 1) ? $clog2(STABLE_CYC) : 1;
    localparam logic [QCNT_W-1:0] QCNT_LAST = QCNT_W'(STABLE_CYC - 1);

    logic [SYNC_STAGES-1:0] pll_sync;
    logic [SYNC_STAGES-1:0] ltr_sync;
    logic                   lock_ok;
    logic                   loss_evt;
    logic [QCNT_W-1:0]      qcnt;
    lock_state_e            state_q;
    lock_state_e            state_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            pll_sync <= '0;
            ltr_sync <= '0;
        end else begin
            pll_sync <= {pll_sync[SYNC_STAGES-2:0], pll_locked};
            ltr_sync <= {ltr_sync[SYNC_STAGES-2:0], rx_is_lockedtoref};
        end
    end

    assign pll_locked_s        = pll_sync[SYNC_STAGES-1];
    assign rx_is_lockedtoref_s = ltr_sync[SYNC_STAGES-1];
    assign lock_ok             = pll_locked_s & rx_is_lockedtoref_s;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= UNLOCKED;
        end else begin
            state_q <= state_d;
        end
    end

    // A loopback change restarts qualification regardless of the current lock state.
    always_comb begin
        state_d = state_q;
        if (relock) begin
            state_d = UNLOCKED;
        end else begin
            case (state_q)
                UNLOCKED: if (lock_ok) state_d = QUALIFY;
                QUALIFY:  if (!lock_ok) state_d = UNLOCKED;
                          else if (qcnt == QCNT_LAST) state_d = LOCKED;
                LOCKED:   if (!lock_ok) state_d = UNLOCKED;
                default:  state_d = UNLOCKED;
            endcase
        end
    end

    always_comb begin
        stable   = (state_q == LOCKED);
        loss_evt = (state_q == LOCKED) && !lock_ok && !relock;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            qcnt <= '0;
        end else if (state_q == QUALIFY && state_d == QUALIFY) begin
            qcnt <= qcnt + QCNT_W'(1);
        end else begin
            qcnt <= '0;
        end
    end

    // A clear coinciding with a loss leaves the new loss counted.
    always_ff @(posedge clk) begin
        if (reset) begin
            loss_cnt    <= '0;
            loss_sticky <= 1'b0;
        end else begin
            loss_sticky <= (loss_sticky & ~sticky_clr) | loss_evt;
            if (cnt_clr) begin
                loss_cnt <= loss_evt ? CNT_W'(1) : '0;
            end else if (loss_evt && (loss_cnt != {CNT_W{1'b1}})) begin
                loss_cnt <= loss_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/nativephy_link_monitor.sv
// rtl/nativephy_link_monitor.sv - CSR block for Native PHY loopback control and lock-health monitoring
module nativephy_link_monitor
    import nativephy_link_pkg::*;
#(
    parameter int NUM_OF_CH   = 4,
    parameter int CNT_W       = 16,
    parameter int SYNC_STAGES = 2,
    parameter int STABLE_CYC  = 1024
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [3:0]           csr_address,
    input  logic                 csr_read,
    input  logic                 csr_write,
    input  logic [31:0]          csr_writedata,
    output logic [31:0]          csr_readdata,
    input  logic [NUM_OF_CH-1:0] pll_locked,
    input  logic [NUM_OF_CH-1:0] rx_is_lockedtoref,
    output logic [NUM_OF_CH-1:0] rx_seriallpbken,
    output logic [NUM_OF_CH-1:0] rx_seriallpbken_mon,
    output logic                 irq
);

    logic [NUM_OF_CH-1:0] lpbk_ctrl;
    logic [NUM_OF_CH-1:0] irq_en;
    logic [4:0]           cnt_sel;
    logic [NUM_OF_CH-1:0] pll_s;
    logic [NUM_OF_CH-1:0] ltr_s;
    logic [NUM_OF_CH-1:0] stable;
    logic [NUM_OF_CH-1:0] sticky;
    logic [NUM_OF_CH-1:0] relock;
    logic [NUM_OF_CH-1:0] sticky_clr;
    logic [CNT_W-1:0]     loss_cnt [NUM_OF_CH];
    logic [CNT_W-1:0]     sel_cnt;
    logic [31:0]          rd_mux;
    logic                 wr_lpbk;
    logic                 wr_cnt;
    logic                 unused_wdata;

    assign wr_lpbk      = csr_write && (csr_address == ADDR_LPBK_CTRL);
    assign wr_cnt       = csr_write && (csr_address == ADDR_LOSS_CNT);
    assign relock       = wr_lpbk ? (csr_writedata[NUM_OF_CH-1:0] ^ lpbk_ctrl) : '0;
    assign sticky_clr   = (csr_write && (csr_address == ADDR_LOSS_STICKY)) ?
                          csr_writedata[NUM_OF_CH-1:0] : '0;
    assign unused_wdata = ^csr_writedata;

    for (genvar i = 0; i < NUM_OF_CH; i++) begin : g_ch
        nativephy_lock_qual #(
            .CNT_W       (CNT_W),
            .SYNC_STAGES (SYNC_STAGES),
            .STABLE_CYC  (STABLE_CYC)
        ) u_qual (
            .clk                 (clk),
            .reset               (reset),
            .pll_locked          (pll_locked[i]),
            .rx_is_lockedtoref   (rx_is_lockedtoref[i]),
            .relock              (relock[i]),
            .sticky_clr          (sticky_clr[i]),
            .cnt_clr             (wr_cnt && (cnt_sel == 5'(i))),
            .pll_locked_s        (pll_s[i]),
            .rx_is_lockedtoref_s (ltr_s[i]),
            .stable              (stable[i]),
            .loss_sticky         (sticky[i]),
            .loss_cnt            (loss_cnt[i])
        );
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            lpbk_ctrl <= '0;
            irq_en    <= '0;
            cnt_sel   <= '0;
            irq       <= 1'b0;
        end else begin
            if (wr_lpbk) lpbk_ctrl <= csr_writedata[NUM_OF_CH-1:0];
            if (csr_write && (csr_address == ADDR_IRQ_EN)) irq_en <= csr_writedata[NUM_OF_CH-1:0];
            if (csr_write && (csr_address == ADDR_CNT_SEL)) cnt_sel <= csr_writedata[4:0];
            irq <= |(sticky & irq_en);
        end
    end

    assign rx_seriallpbken     = lpbk_ctrl;
    assign rx_seriallpbken_mon = lpbk_ctrl;

    // Out-of-range selects match no channel and read as zero.
    always_comb begin
        sel_cnt = '0;
        for (int i = 0; i < NUM_OF_CH; i++) begin
            if (cnt_sel == 5'(i)) sel_cnt = loss_cnt[i];
        end
    end

    always_comb begin
        rd_mux = '0;
        case (csr_address)
            ADDR_LPBK_CTRL:   rd_mux = 32'(lpbk_ctrl);
            ADDR_PLL_LOCKED:  rd_mux = 32'(pll_s);
            ADDR_RX_LTR:      rd_mux = 32'(ltr_s);
            ADDR_RX_STABLE:   rd_mux = 32'(stable);
            ADDR_LOSS_STICKY: rd_mux = 32'(sticky);
            ADDR_IRQ_EN:      rd_mux = 32'(irq_en);
            ADDR_CNT_SEL:     rd_mux = 32'(cnt_sel);
            ADDR_LOSS_CNT:    rd_mux = 32'(sel_cnt);
            ADDR_VERSION:     rd_mux = VERSION_VALUE;
            default:          rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            csr_readdata <= '0;
        end else if (csr_read) begin
            csr_readdata <= rd_mux;
        end
    end

endmodule
